spu_nop_lanes: RTL

//  Multi-lane successor to the single-lane pipelined no-op stage. It carries CHANNELS data lanes through a

---
 rtl/spu_pkg.sv | 23 ++
 rtl/spu_nop_lanes_if.sv | 34 +++
 rtl/spu_conv.sv | 56 +++++
 rtl/spu_nop_lanes.sv | 115 +++++++++++
 4 files changed

// File: rtl/spu_pkg.sv
// Shared SPU definitions: lane width-conversion modes and the signed
// clamp limits used by the saturating converter.
//   conv_mode_t : CONV_WRAP (signed extend / truncate), CONV_UNSIGNED
//                 (zero extend / truncate), CONV_SAT (signed extend / clamp)
//   sat_max     : largest two's-complement value representable in 'bits'
//   sat_min     : smallest two's-complement value representable in 'bits'
package spu_pkg;

  typedef enum logic [1:0] {
    CONV_WRAP     = 2'd0,
    CONV_UNSIGNED = 2'd1,
    CONV_SAT      = 2'd2
  } conv_mode_t;

  function automatic logic signed [63:0] sat_max(input int bits);
    return (64'sd1 <<< (bits - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int bits);
    return -(64'sd1 <<< (bits - 1));
  endfunction

endpackage

// File: rtl/spu_nop_lanes_if.sv
// Beat bus of the multi-lane no-op stage.
//   s_valid / s_lane_en / s_data : input beat (driven by the producer)
//   m_valid / m_lane_en / m_data / m_sat / m_count : delayed, converted beat
// Lane i of s_data is s_data[i*S_DATA_BITS +: S_DATA_BITS]; the same
// packing applies to m_data with M_DATA_BITS.
//   master : producer/consumer side (drives s_*, observes m_*)
//   slave  : the pipeline itself (observes s_*, drives m_*)
interface spu_nop_lanes_if #(
  parameter int LATENCY     = 1,
  parameter int CHANNELS    = 4,
  parameter int S_DATA_BITS = 8,
  parameter int M_DATA_BITS = 8
);
  localparam int CNT_BITS = $clog2(LATENCY + 1) + 1;

  logic                            s_valid;
  logic [CHANNELS-1:0]             s_lane_en;
  logic [CHANNELS*S_DATA_BITS-1:0] s_data;
  logic                            m_valid;
  logic [CHANNELS-1:0]             m_lane_en;
  logic [CHANNELS*M_DATA_BITS-1:0] m_data;
  logic [CHANNELS-1:0]             m_sat;
  logic [CNT_BITS-1:0]             m_count;

  modport master (
    output s_valid, s_lane_en, s_data,
    input  m_valid, m_lane_en, m_data, m_sat, m_count
  );

  modport slave (
    input  s_valid, s_lane_en, s_data,
    output m_valid, m_lane_en, m_data, m_sat, m_count
  );
endinterface

// File: rtl/spu_conv.sv
// Single-lane combinational width converter.
//   s_data : S_DATA_BITS input lane
//   s_en   : lane enable; a disabled lane yields data 0, sat 0
//   m_data : M_DATA_BITS converted lane
//   m_sat  : 1 when CONV_SAT had to clamp the value
module spu_conv
  import spu_pkg::*;
#(
  parameter int         S_DATA_BITS = 8,
  parameter int         M_DATA_BITS = 8,
  parameter conv_mode_t CONV_MODE   = CONV_WRAP
) (
  input  logic [S_DATA_BITS-1:0] s_data,
  input  logic                   s_en,
  output logic [M_DATA_BITS-1:0] m_data,
  output logic                   m_sat
);

  logic signed [S_DATA_BITS-1:0] sdata;
  logic        [M_DATA_BITS-1:0] raw;
  logic                          raw_sat;

  assign sdata = s_data;

  if (M_DATA_BITS >= S_DATA_BITS) begin : g_widen
    // Widening never overflows, so no clamp is possible in any mode.
    always_comb begin
      raw_sat = 1'b0;
      if (CONV_MODE == CONV_UNSIGNED) raw = M_DATA_BITS'(s_data);
      else                            raw = M_DATA_BITS'(sdata);
    end
  end else begin : g_narrow
    localparam logic signed [63:0] HI = sat_max(M_DATA_BITS);
    localparam logic signed [63:0] LO = sat_min(M_DATA_BITS);
    logic signed [63:0] wide;

    always_comb begin
      wide    = 64'(sdata);
      raw     = s_data[M_DATA_BITS-1:0];
      raw_sat = 1'b0;
      if (CONV_MODE == CONV_SAT) begin
        if (wide > HI) begin
          raw     = HI[M_DATA_BITS-1:0];
          raw_sat = 1'b1;
        end else if (wide < LO) begin
          raw     = LO[M_DATA_BITS-1:0];
          raw_sat = 1'b1;
        end
      end
    end
  end

  assign m_data = s_en ? raw : '0;
  assign m_sat  = s_en & raw_sat;

endmodule

// File: rtl/spu_nop_lanes.sv
// Multi-lane pipelined no-op stage with width conversion.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low; clears every stage and the counter
//   cke   : pipeline advances only when 1
//   flush : clears all in-flight valids on the next edge (regardless of cke)
//   bus   : slave side of spu_nop_lanes_if (s_* beat in, m_* beat out,
//           m_sat per-lane clamp flags, m_count beats in flight)
// LATENCY==0 gives a combinational converter with m_count tied to 0.
module spu_nop_lanes
  import spu_pkg::*;
#(
  parameter int         LATENCY     = 1,
  parameter int         CHANNELS    = 4,
  parameter int         S_DATA_BITS = 8,
  parameter int         M_DATA_BITS = 8,
  parameter conv_mode_t CONV_MODE   = CONV_WRAP,
  parameter int         CNT_BITS    = $clog2(LATENCY + 1) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cke,
  input  logic            flush,
  spu_nop_lanes_if.slave  bus
);

  localparam int DW = CHANNELS * M_DATA_BITS;

  typedef struct packed {
    logic                valid;
    logic [CHANNELS-1:0] lane_en;
    logic [DW-1:0]       data;
    logic [CHANNELS-1:0] sat;
  } beat_t;

  logic [DW-1:0]       conv_data;
  logic [CHANNELS-1:0] conv_sat;
  beat_t               conv;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    spu_conv #(
      .S_DATA_BITS (S_DATA_BITS),
      .M_DATA_BITS (M_DATA_BITS),
      .CONV_MODE   (CONV_MODE)
    ) u_conv (
      .s_data (bus.s_data[i*S_DATA_BITS +: S_DATA_BITS]),
      .s_en   (bus.s_lane_en[i]),
      .m_data (conv_data[i*M_DATA_BITS +: M_DATA_BITS]),
      .m_sat  (conv_sat[i])
    );
  end

  assign conv = {bus.s_valid, bus.s_lane_en, conv_data, conv_sat};

  if (LATENCY == 0) begin : g_comb
    assign bus.m_valid   = conv.valid;
    assign bus.m_lane_en = conv.lane_en;
    assign bus.m_data    = conv.data;
    assign bus.m_sat     = conv.sat;
    assign bus.m_count   = '0;
  end else begin : g_pipe
    logic [LATENCY-1:0]  vld_p;
    logic [CNT_BITS-1:0] cnt;
    logic                last_vld;

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
      beat_t prev;
      beat_t q_p;

      if (k == 0) begin : g_head
        assign prev = conv;
      end else begin : g_body
        assign prev = g_stage[k-1].q_p;
      end

      // ---- stage k register boundary ----
      // Flush only touches valid; stage 0 still accepts the incoming beat
      // when the pipeline is enabled in the same cycle.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          q_p <= '0;
        end else begin
          if (cke) q_p <= prev;
          if (flush) q_p.valid <= (k == 0) ? (cke & conv.valid) : 1'b0;
        end
      end

      assign vld_p[k] = q_p.valid;
    end

    assign last_vld = g_stage[LATENCY-1].q_p.valid;

    // Registered occupancy: tracks accepted beats minus departing beats so
    // it always equals the number of set stage valids.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt <= '0;
      end else if (flush) begin
        cnt <= CNT_BITS'(cke & bus.s_valid);
      end else if (cke) begin
        cnt <= cnt + CNT_BITS'(bus.s_valid) - CNT_BITS'(last_vld);
      end
    end

    a_count_matches_valids : assert property (
      @(posedge clk) disable iff (!reset) cnt == CNT_BITS'($countones(vld_p))
    );

    assign bus.m_valid   = g_stage[LATENCY-1].q_p.valid;
    assign bus.m_lane_en = g_stage[LATENCY-1].q_p.lane_en;
    assign bus.m_data    = g_stage[LATENCY-1].q_p.data;
    assign bus.m_sat     = g_stage[LATENCY-1].q_p.sat;
    assign bus.m_count   = cnt;
  end

endmodule
